// File: rtl/ladybird_ifu_fq_pkg.sv
// Shared fetch-unit widths and the per-instruction queue entry type.
// Imported by the fetch queue top and its ring buffer.
package ladybird_config;
   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } ifu_entry_t;
endpackage

// File: rtl/ladybird_ifu_fq_fetch_fifo.sv
// DEPTH-entry ring of fetch entries; up to INSTS pushes and one pop per cycle, synchronous flush.
// Registered storage: a push at edge t is readable at head from t+1; the writer must respect count.
module ladybird_fetch_fifo
   import ladybird_config::*;
#(
   parameter int DEPTH = 8,
   parameter int INSTS = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1,
   localparam int PW = $clog2(INSTS) + 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  flush,
   input  logic [PW-1:0]         push_cnt,
   input  ifu_entry_t [INSTS-1:0] push_data,
   input  logic                  pop,
   output ifu_entry_t            head,
   output logic [CW-1:0]         count
);
   ifu_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!nrst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_cnt);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + CW'(push_cnt) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (nrst && !flush) begin
         for (int i = 0; i < INSTS; i++) begin
            if (i < int'(push_cnt)) mem[wr_ptr + AW'(i)] <= push_data[i];
         end
      end
   end

   // Space is judged against the pre-pop count, matching the admission rule upstream.
   always_ff @(posedge clk) begin
      if (nrst && !flush) assert (CW'(push_cnt) <= CW'(DEPTH) - count);
   end
endmodule

// File: rtl/ladybird_ifu_fq.sv
// Fetch unit: holds fetch PC, requests one cache line at a time and unpacks it into the fetch queue.
// Queue head valid the cycle after a push; requests wait for queue space (LADYBIRD_IFU_PREFETCH_EN: prefetch while draining).
module ladybird_ifu_fq
   import ladybird_config::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
   parameter int              LINE_BITS = 128,
   parameter int              DEPTH     = 8
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   output logic                 cache_req,
   output logic [XLEN-1:0]      cache_addr,
   input  logic                 cache_ready,
   input  logic                 cache_rvalid,
   input  logic [XLEN-1:0]      cache_raddr,
   input  logic [LINE_BITS-1:0] cache_rdata,
   output logic                 inst_valid,
   output logic [ILEN-1:0]      inst,
   output logic [XLEN-1:0]      inst_pc,
   input  logic                 inst_ready
);
   localparam int INSTS      = LINE_BITS / 32;
   localparam int LINE_BYTES = LINE_BITS / 8;
   localparam int AW         = $clog2(DEPTH);
   localparam int CW         = AW + 1;
   localparam int PW         = $clog2(INSTS) + 1;
   localparam logic [XLEN-1:0] LINE_MASK = XLEN'(LINE_BYTES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  fetch_pc_nxt;
   logic [XLEN-1:0]  line_base;
   logic [XLEN-1:0]  resp_base;
   logic [XLEN-1:0]  word_off;
   logic [XLEN-1:0]  need;
   logic [CW-1:0]    count;
   logic             admit;
   logic             pop;
   logic             push;
   logic [PW-1:0]    push_cnt;
   ifu_entry_t [INSTS-1:0] push_data;
   ifu_entry_t       head;

   assign line_base = fetch_pc & ~LINE_MASK;
   assign resp_base = cache_raddr & ~LINE_MASK;
   assign word_off  = (fetch_pc & LINE_MASK) >> 2;
   assign need      = XLEN'(INSTS) - word_off;

   assign pop      = inst_valid && inst_ready;
   assign push     = (state == S_WAIT) && cache_rvalid && !redirect_valid;
   assign push_cnt = push ? PW'(need) : '0;

`ifdef LADYBIRD_IFU_PREFETCH_EN
   logic [CW-1:0] free;
   assign free  = CW'(DEPTH) - count;
   assign admit = XLEN'(free) >= need;
`else
   assign admit = (count == '0) || ((count == CW'(1)) && pop);
`endif

   // Words below the fetch offset belong to instructions before the fetch target.
   always_comb begin
      push_data = '0;
      for (int j = 0; j < INSTS; j++) begin
         if (j + int'(word_off) < INSTS) begin
            push_data[j].pc   = resp_base + XLEN'(4 * (j + int'(word_off)));
            push_data[j].inst = cache_rdata[32 * (j + int'(word_off)) +: 32];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      case (state)
         S_IDLE: if (admit) state_nxt = S_REQ;
         S_REQ:  if (cache_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            if (cache_rvalid) begin
               state_nxt    = S_IDLE;
               fetch_pc_nxt = line_base + XLEN'(LINE_BYTES);
            end
         end
         S_DROP: if (cache_rvalid) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // A request already accepted by the cache must have its response swallowed in DROP.
      if (redirect_valid) begin
         fetch_pc_nxt = redirect_pc & ~XLEN'(3);
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_REQ:   state_nxt = cache_ready ? S_DROP : S_IDLE;
            S_WAIT:  state_nxt = cache_rvalid ? S_IDLE : S_DROP;
            default: state_nxt = state_nxt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   ladybird_fetch_fifo #(
      .DEPTH (DEPTH),
      .INSTS (INSTS)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .flush     (redirect_valid),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign cache_req  = (state == S_REQ);
   assign cache_addr = cache_req ? line_base : '0;
   assign inst_valid = (count != '0);
   assign inst       = inst_valid ? head.inst : '0;
   assign inst_pc    = inst_valid ? head.pc : '0;
endmodule

// File: tb/tb_ladybird_ifu_fq.sv
// Bench for ladybird_ifu_fq: a line-granular cache model feeds the DUT while a scoreboard expects
// the sequential instruction stream from the last reset/redirect target, word value derived from its PC.
module tb_ladybird_ifu_fq;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         redirect_valid = 1'b0;
   logic [31:0]  redirect_pc = '0;
   logic         cache_req;
   logic [31:0]  cache_addr;
   logic         cache_ready = 1'b0;
   logic         cache_rvalid = 1'b0;
   logic [31:0]  cache_raddr = '0;
   logic [127:0] cache_rdata = '0;
   logic         inst_valid;
   logic [31:0]  inst;
   logic [31:0]  inst_pc;
   logic         inst_ready = 1'b0;

   ladybird_ifu_fq dut (
      .clk            (clk),
      .nrst           (nrst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .cache_req      (cache_req),
      .cache_addr     (cache_addr),
      .cache_ready    (cache_ready),
      .cache_rvalid   (cache_rvalid),
      .cache_raddr    (cache_raddr),
      .cache_rdata    (cache_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          pops = 0;
   logic [31:0] expq[$];
   logic [31:0] exp_tail = RESET_PC;
   logic [31:0] req_log[$];
   logic [31:0] mon_pc;
   logic [31:0] req_a;
   int          lat;
   logic        outstanding = 1'b0;
   logic        stale = 1'b0;
   logic        always_ready = 1'b1;
   int          fixed_lat = 1;
   int          rdy_mode = 1;

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF ^ {pc[15:0], pc[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic chk_req(input string name, input int idx, input logic [31:0] exp);
      if (idx < req_log.size()) chk(name, req_log[idx], exp);
      else begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: request %0d never issued, want %h", name, idx, exp);
      end
   endtask

   task automatic sb_restart(input logic [31:0] pc);
      expq.delete();
      exp_tail = pc;
      for (int i = 0; i < 16; i++) begin
         expq.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      if (outstanding) stale = 1'b1;
      sb_restart(pc & ~32'd3);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      chk("flush_clears_valid", 32'(inst_valid), 32'd0);
      #1;
   endtask

   task automatic wait_pops(input string name, input int n);
      int start = pops;
      int c = 0;
      while (pops < start + n && c < 3000) begin
         cycle();
         c++;
      end
      chk(name, 32'(pops >= start + n), 32'd1);
   endtask

   task automatic wait_in_wait(input string name);
      int c = 0;
      while (!(outstanding && !cache_rvalid) && c < 500) begin
         cycle();
         c++;
      end
      chk(name, 32'(outstanding && !cache_rvalid), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cache_req"},  32'(cache_req),  32'd0);
      chk({tag, "_cache_addr"}, cache_addr,      32'd0);
      chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      chk({tag, "_inst"},       inst,            32'd0);
      chk({tag, "_inst_pc"},    inst_pc,         32'd0);
   endtask

   // Monitor: every accepted head entry must be the next expected PC in the stream.
   always @(negedge clk) begin
      if (nrst && inst_valid && inst_ready && !redirect_valid) begin
         while (expq.size() < 8) begin
            expq.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
         end
         mon_pc = expq.pop_front();
         chk("inst_pc", inst_pc, mon_pc);
         chk("inst_word", inst, word_of(mon_pc));
         pops++;
      end
   end

   // Cache model: one request at a time, lines returned after lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (nrst && cache_req && cache_ready) begin
            req_log.push_back(cache_addr);
            chk("req_line_aligned", {28'd0, cache_addr[3:0]}, 32'd0);
            req_a       = cache_addr;
            outstanding = 1'b1;
            stale       = redirect_valid;
            @(posedge clk);
            #1;
            cache_ready = 1'b0;
            lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            repeat (lat - 1) begin
               @(posedge clk);
               #1;
            end
            cache_raddr = req_a;
            for (int k = 0; k < 4; k++)
               cache_rdata[32 * k +: 32] = stale ? 32'hDEAD_BEEF : word_of(req_a + 32'(4 * k));
            cache_rvalid = 1'b1;
            @(posedge clk);
            #1;
            cache_rvalid = 1'b0;
            outstanding  = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
         cache_ready = always_ready || ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         inst_ready = (rdy_mode == 1) || ((rdy_mode == 0) && ($urandom_range(0, 2) != 0));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
      $fatal(1);
   end

   initial begin
      int idx;
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("reset");
      sb_restart(RESET_PC);
      nrst = 1'b1;

      // Straight-line streaming from the reset PC.
      wait_pops("stream_from_reset", 12);
      chk_req("first_req", 0, 32'h8000_0000);
      chk_req("second_req", 1, 32'h8000_0010);

      // Mid-line redirect: only the tail of the first line is delivered.
      redirect(32'h8000_0108);
      idx = req_log.size();
      wait_pops("stream_after_redirect", 6);
      chk_req("redirect_line_req", idx, 32'h8000_0100);
      chk_req("redirect_next_req", idx + 1, 32'h8000_0110);

      // Backpressure: queue fills and fetch stops, then drains in order.
      rdy_mode = 2;
      repeat (20) cycle();
      for (int i = 0; i < 5; i++) begin
         chk("stall_no_req", 32'(cache_req), 32'd0);
         chk("stall_head_valid", 32'(inst_valid), 32'd1);
         cycle();
      end
      rdy_mode = 1;
      wait_pops("drain_after_stall", 12);

      // Redirect while waiting; the stale line arrives later and must vanish.
      fixed_lat = 4;
      wait_in_wait("reach_wait_state");
      redirect(32'h8000_0204);
      wait_pops("stream_after_wait_redirect", 8);

      // Redirect coinciding with the response.
      fixed_lat = 2;
      begin
         int c = 0;
         while (!cache_rvalid && c < 500) begin cycle(); c++; end
      end
      chk("see_rvalid", 32'(cache_rvalid), 32'd1);
      redirect(32'h8000_0308);
      wait_pops("stream_after_rvalid_redirect", 8);

      // Redirect coinciding with the request handshake.
      fixed_lat = 1;
      begin
         int c = 0;
         while (!(cache_req && cache_ready) && c < 500) begin cycle(); c++; end
      end
      chk("see_handshake", 32'(cache_req && cache_ready), 32'd1);
      redirect(32'h8000_0404);
      wait_pops("stream_after_req_redirect", 8);

      // Address wrap at the top of the address space.
      redirect(32'hFFFF_FFF0);
      idx = req_log.size();
      wait_pops("stream_across_wrap", 8);
      chk_req("wrap_first_req", idx, 32'hFFFF_FFF0);
      chk_req("wrap_next_req", idx + 1, 32'h0000_0000);

      // Reset while a response is outstanding.
      redirect(32'h8000_0500);
      fixed_lat = 3;
      wait_in_wait("reach_wait_for_reset");
      nrst  = 1'b0;
      stale = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("midreset");
      sb_restart(RESET_PC);
      idx  = req_log.size();
      nrst = 1'b1;
      #1;
      fixed_lat = 0;
      wait_pops("stream_after_midreset", 8);
      chk_req("midreset_first_req", idx, RESET_PC);

      // Random backpressure, cache stalls, latencies and redirects.
      always_ready = 1'b0;
      rdy_mode     = 0;
      for (int i = 0; i < 1500; i++) begin
         cycle();
         if ($urandom_range(0, 39) == 0)
            redirect(32'h8000_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3));
      end
      rdy_mode     = 1;
      always_ready = 1'b1;
      wait_pops("final_stream", 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
